spi_master_shifter: RTL and testbench
=====================================

// Module: spi_master_shifter
// PURPOSE
//  Parametrised SPI master transmit/receive shifter; successor to the fixed 8-bit shifter.
//  Generates SCLK from the system clock by an internal divider and supports all four CPOL/CPHA modes.
//  Frame width and bit order are configurable; provides chip-select framing and a done pulse.
//  Sits between a host register/FSM and the off-chip SPI pins.
// PARAMETERS
//  DATA_W     8   frame width in bits (>=2)
//  CLK_DIV    28  clk cycles per SCLK half-period (>=1)
//  CPOL       0   SCLK idle level
//  CPHA       0   0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//  MSB_FIRST  1   1: bit DATA_W-1 first; 0: bit 0 first
// PORTS
//  clk             in   1       system clock; all logic on posedge
//  rst_n           in   1       asynchronous active-low reset
//  data_buffer     in   DATA_W  transmit word; latched on accepted start
//  start_transfer  in   1       request; level-sampled while idle
//  data_out        out  1       MOSI
//  clk_out         out  1       SCLK
//  cs_n            out  1       chip select, active low
//  busy            out  1       frame in progress
//  done            out  1       1-cycle pulse at frame end
//  miso            in   1       serial input          (SPI_MISO_EN only)
//  rx_data         out  DATA_W  last received word    (SPI_MISO_EN only)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, clk_out=CPOL, cs_n=1, data_out=0, busy=0, done=0,
//   rx_data=0, counters cleared; takes effect immediately, also mid-frame (frame aborted, no done).
//  FSM IDLE -> SETUP -> SHIFT -> HOLD -> IDLE. Half-period counter hp_cnt 0..CLK_DIV-1.
//  IDLE: start_transfer=1 at posedge -> latch data_buffer into shift reg, next cycle busy=1, cs_n=0,
//   state SETUP. start_transfer while busy is ignored (no queueing).
//  SETUP: CLK_DIV cycles, clk_out=CPOL. CPHA=0: first bit already driven on data_out.
//  SHIFT: 2*DATA_W half-periods; clk_out toggles at end of each half-period (odd toggles = leading).
//   CPHA=0: sample miso on leading edge; drive next bit on trailing edge (none after last bit).
//   CPHA=1: drive bit on leading edge; sample miso on trailing edge.
//   Bit order per MSB_FIRST for both transmit and receive.
//  HOLD: CLK_DIV cycles, clk_out=CPOL, data_out holds last bit, cs_n=0.
//  End: on leaving HOLD: cs_n=1, busy=0, done=1 for exactly one cycle, state IDLE;
//   rx_data updated in the same cycle as done; data_out returns to 0.
//  busy high for exactly CLK_DIV*(2*DATA_W+2) cycles per frame.
//  Back-to-back: start_transfer high in the done cycle is accepted; cs_n high exactly 1 cycle between frames.
//  data_buffer changes during a frame do not affect the frame in progress.
// CONFIGURATION
//  SPI_MISO_EN defined: miso port, receive shift register and rx_data present; full-duplex.
//  SPI_MISO_EN undefined: miso/rx_data ports absent, no receive logic; transmit timing identical.
// TESTING  (DATA_W=8, CLK_DIV=2 unless noted)
//  Mode 0, MSB first, data 0xAA, start 1 cycle -> MOSI 1,0,1,0,1,0,1,0 valid at each SCLK rising edge;
//   busy high 36 cycles; one done pulse; cs_n low throughout busy.
//  Mode 3 (CPOL=1,CPHA=1), SPI_MISO_EN, miso tied to data_out, data 0xA5 -> SCLK idles high,
//   rx_data=0xA5 in done cycle.
//  MSB_FIRST=0, data 0x01 -> first MOSI bit 1, remaining seven 0.
//  start_transfer pulsed mid-frame with data 0xFF -> ignored; frame still carries 0xAA; single done.
//  rst_n low at bit 4 -> immediately cs_n=1, clk_out=CPOL, busy=0; no done; next start gives full frame.
//  start_transfer held high, CLK_DIV=1 -> consecutive frames of 18 busy cycles, cs_n high 1 cycle between.

Source files
------------

// File: rtl/spi_master_shifter.sv
// -----------------------------------------------------------------------------
// spi_master_shifter
//
// Parametrised SPI master transmit/receive shifter. SCLK is derived from clk
// by an internal half-period divider, and all four CPOL/CPHA modes are
// supported. Frame width and bit order are configurable. A frame runs
// SETUP (one half-period, cs_n low) -> SHIFT (2*DATA_W half-periods)
// -> HOLD (one half-period) and then returns to IDLE with a one-cycle done
// pulse.
//
// Optional feature macro: SPI_MISO_EN
//   defined   : miso input, receive shift register and rx_data output present
//   undefined : transmit only, no receive logic or ports
//
// Ports
//   clk             in   1       system clock, all logic on posedge
//   rst_n           in   1       asynchronous active-low reset
//   data_buffer     in   DATA_W  transmit word, latched when start is accepted
//   start_transfer  in   1       transfer request, level-sampled while idle
//   data_out        out  1       MOSI
//   clk_out         out  1       SCLK
//   cs_n            out  1       chip select, active low
//   busy            out  1       frame in progress
//   done            out  1       one-cycle pulse at frame end
//   miso            in   1       serial input            (SPI_MISO_EN only)
//   rx_data         out  DATA_W  last received word      (SPI_MISO_EN only)
// -----------------------------------------------------------------------------
module spi_master_shifter #(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 28,
   parameter bit CPOL      = 1'b0,
   parameter bit CPHA      = 1'b0,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_buffer,
   input  logic              start_transfer,
   output logic              data_out,
   output logic              clk_out,
   output logic              cs_n,
   output logic              busy,
   output logic              done
`ifdef SPI_MISO_EN
   ,
   input  logic              miso,
   output logic [DATA_W-1:0] rx_data
`endif
);

   localparam int HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EC_W = $clog2(2 * DATA_W);
   localparam logic [HP_W-1:0] HP_LAST = HP_W'(CLK_DIV - 1);
   localparam logic [EC_W-1:0] EC_LAST = EC_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Bit that goes on the wire next, according to bit order.
   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   // Discard the bit just transmitted.
   function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
   endfunction

   // Insert a received bit so the word ends up in natural order for both bit orders.
   function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] w,
                                                  input logic             b);
      return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
   endfunction

   state_t            state, state_nxt;
   logic [HP_W-1:0]   hp_cnt, hp_cnt_nxt;
   logic [EC_W-1:0]   edge_cnt, edge_cnt_nxt;
   logic [DATA_W-1:0] tx_sr, tx_sr_nxt;
   logic              data_out_nxt;
   logic              clk_out_nxt;
   logic              cs_n_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic              hp_end;
   logic              leading;
`ifdef SPI_MISO_EN
   logic [DATA_W-1:0] rx_sr, rx_sr_nxt;
   logic [DATA_W-1:0] rx_data_nxt;
`endif

   assign hp_end  = (hp_cnt == HP_LAST);
   // Edges are counted from 0, so even counts are the odd (leading) toggles.
   assign leading = ~edge_cnt[0];

   always_comb begin
      state_nxt    = state;
      hp_cnt_nxt   = hp_cnt;
      edge_cnt_nxt = edge_cnt;
      tx_sr_nxt    = tx_sr;
      data_out_nxt = data_out;
      clk_out_nxt  = clk_out;
      cs_n_nxt     = cs_n;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
`ifdef SPI_MISO_EN
      rx_sr_nxt    = rx_sr;
      rx_data_nxt  = rx_data;
`endif

      case (state)
         IDLE: begin
            if (start_transfer) begin
               state_nxt    = SETUP;
               hp_cnt_nxt   = '0;
               edge_cnt_nxt = '0;
               cs_n_nxt     = 1'b0;
               busy_nxt     = 1'b1;
               clk_out_nxt  = CPOL;
               // With CPHA=0 the first bit must be on the line before the first edge.
               if (!CPHA) begin
                  data_out_nxt = first_bit(data_buffer);
                  tx_sr_nxt    = shift_tx(data_buffer);
               end else begin
                  tx_sr_nxt    = data_buffer;
               end
            end
         end

         SETUP: begin
            if (hp_end) begin
               hp_cnt_nxt = '0;
               state_nxt  = SHIFT;
            end else begin
               hp_cnt_nxt = hp_cnt + 1'b1;
            end
         end

         SHIFT: begin
            if (hp_end) begin
               hp_cnt_nxt   = '0;
               clk_out_nxt  = ~clk_out;
               edge_cnt_nxt = edge_cnt + 1'b1;
               if (leading ^ CPHA) begin
`ifdef SPI_MISO_EN
                  rx_sr_nxt = shift_rx(rx_sr, miso);
`endif
               end else if (CPHA || (edge_cnt != EC_LAST)) begin
                  // No new bit after the final trailing edge in CPHA=0.
                  data_out_nxt = first_bit(tx_sr);
                  tx_sr_nxt    = shift_tx(tx_sr);
               end
               if (edge_cnt == EC_LAST) begin
                  edge_cnt_nxt = '0;
                  state_nxt    = HOLD;
               end
            end else begin
               hp_cnt_nxt = hp_cnt + 1'b1;
            end
         end

         HOLD: begin
            if (hp_end) begin
               hp_cnt_nxt   = '0;
               state_nxt    = IDLE;
               cs_n_nxt     = 1'b1;
               busy_nxt     = 1'b0;
               done_nxt     = 1'b1;
               data_out_nxt = 1'b0;
`ifdef SPI_MISO_EN
               rx_data_nxt  = rx_sr;
`endif
            end else begin
               hp_cnt_nxt = hp_cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hp_cnt   <= '0;
         edge_cnt <= '0;
         data_out <= 1'b0;
         clk_out  <= CPOL;
         cs_n     <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef SPI_MISO_EN
         rx_data  <= '0;
`endif
      end else begin
         state    <= state_nxt;
         hp_cnt   <= hp_cnt_nxt;
         edge_cnt <= edge_cnt_nxt;
         data_out <= data_out_nxt;
         clk_out  <= clk_out_nxt;
         cs_n     <= cs_n_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
`ifdef SPI_MISO_EN
         rx_data  <= rx_data_nxt;
`endif
      end
   end

   // Shift registers hold data only; their contents are always reloaded before use.
   always_ff @(posedge clk) begin
      tx_sr <= tx_sr_nxt;
`ifdef SPI_MISO_EN
      rx_sr <= rx_sr_nxt;
`endif
   end

endmodule

// File: tb/tb_spi_master_shifter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_shifter
//
// Four 8-bit shifter instances in different modes:
//   id0 : mode 0, MSB first, CLK_DIV=2
//   id1 : mode 3, MSB first, CLK_DIV=2
//   id2 : mode 1, LSB first, CLK_DIV=2
//   id3 : mode 2, MSB first, CLK_DIV=1
// With SPI_MISO_EN each instance has miso looped back from its own MOSI.
// -----------------------------------------------------------------------------
module tb_spi_master_shifter;

   localparam int       NI     = 4;
   localparam int       DW     = 8;
   localparam int       DIV_P [NI] = '{2, 2, 2, 1};
   localparam logic [3:0] CPOL_P = 4'b1010;
   localparam logic [3:0] CPHA_P = 4'b0110;
   localparam logic [3:0] MSB_P  = 4'b1011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [NI-1:0] start_v;
   logic [NI-1:0] sclk_v, mosi_v, cs_v, busy_v, done_v;
   logic [DW-1:0] dbuf [NI];
`ifdef SPI_MISO_EN
   logic [DW-1:0] rxd  [NI];
`endif

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      spi_master_shifter #(
         .DATA_W   (DW),
         .CLK_DIV  (DIV_P[g]),
         .CPOL     (CPOL_P[g]),
         .CPHA     (CPHA_P[g]),
         .MSB_FIRST(MSB_P[g])
      ) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .data_buffer   (dbuf[g]),
         .start_transfer(start_v[g]),
         .data_out      (mosi_v[g]),
         .clk_out       (sclk_v[g]),
         .cs_n          (cs_v[g]),
         .busy          (busy_v[g]),
         .done          (done_v[g])
`ifdef SPI_MISO_EN
         ,
         .miso          (mosi_v[g]),
         .rx_data       (rxd[g])
`endif
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Order in which bits appear on the wire: bit 7 of the result is the first bit sent.
   function automatic logic [7:0] wire_order(input logic [7:0] w, input bit msbf);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = msbf ? w[7-i] : w[i];
      return r;
   endfunction

   // Issue a one-cycle start and watch the whole frame from the pins.
   task automatic do_frame(input int id, input logic [7:0] w, input logic [7:0] exp_seq,
                           input int exp_busy, input bit pulse_mid);
      int         nbusy, ndone, csbad, nbits, win;
      logic [7:0] seq;
      logic       prev, lead, cpol, cpha;
      string      tag;
      nbusy = 0; ndone = 0; csbad = 0; nbits = 0; seq = '0;
      cpol = CPOL_P[id];
      cpha = CPHA_P[id];
      win  = DIV_P[id] * 18 + 8;
      tag  = $sformatf("id%0d w=%02h", id, w);

      @(negedge clk);
      dbuf[id]    = w;
      start_v[id] = 1'b1;
      @(negedge clk);
      start_v[id] = 1'b0;
      chk({tag, " busy_rise"}, 32'(busy_v[id]), 32'd1);

      prev = cpol;
      for (int c = 0; c < win; c++) begin
         if (c > 0) @(negedge clk);
         if (busy_v[id]) nbusy++;
         if (busy_v[id] && cs_v[id]) csbad++;
         if (sclk_v[id] !== prev) begin
            lead = (sclk_v[id] != cpol);
            // Data is valid at the edge the slave samples on.
            if (lead != cpha) begin
               if (nbits < 8) seq[7-nbits] = mosi_v[id];
               nbits++;
            end
            prev = sclk_v[id];
         end
         if (done_v[id]) begin
            ndone++;
            chk({tag, " done_cs_n"},  32'(cs_v[id]),   32'd1);
            chk({tag, " done_busy"},  32'(busy_v[id]), 32'd0);
            chk({tag, " done_mosi"},  32'(mosi_v[id]), 32'd0);
            chk({tag, " done_sclk"},  32'(sclk_v[id]), 32'(cpol));
`ifdef SPI_MISO_EN
            chk({tag, " rx_data"},    32'(rxd[id]),    32'(w));
`endif
         end
         if (pulse_mid) begin
            if (c == 10) begin
               dbuf[id]    = 8'hFF;
               start_v[id] = 1'b1;
            end else if (c == 11) begin
               start_v[id] = 1'b0;
            end
         end
      end
      chk({tag, " busy_len"},   32'(nbusy), 32'(exp_busy));
      chk({tag, " done_count"}, 32'(ndone), 32'd1);
      chk({tag, " cs_gaps"},    32'(csbad), 32'd0);
      chk({tag, " edge_bits"},  32'(nbits), 32'd8);
      chk({tag, " mosi_seq"},   32'(seq),   32'(exp_seq));
   endtask

   typedef struct {
      int         id;
      logic [7:0] data;
      bit         pulse;
      logic [7:0] exp_seq;
      int         exp_busy;
   } vec_t;

   initial begin
      vec_t tbl [5];
      int   runs[$];
      int   gaps[$];
      int   run, gap, mism, ndone, id;
      logic [7:0] w;

      tbl[0] = '{0, 8'hAA, 1'b0, 8'hAA, 36};
      tbl[1] = '{1, 8'hA5, 1'b0, 8'hA5, 36};
      tbl[2] = '{2, 8'h01, 1'b0, 8'h80, 36};
      tbl[3] = '{0, 8'hAA, 1'b1, 8'hAA, 36};
      tbl[4] = '{3, 8'h3C, 1'b0, 8'h3C, 18};

      rst_n   = 1'b0;
      start_v = '0;
      for (int i = 0; i < NI; i++) dbuf[i] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset cs_n",  32'(cs_v),   32'hF);
      chk("reset busy",  32'(busy_v), 32'h0);
      chk("reset done",  32'(done_v), 32'h0);
      chk("reset sclk",  32'(sclk_v), 32'(CPOL_P));
      chk("reset mosi",  32'(mosi_v), 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed vectors
      for (int t = 0; t < 5; t++)
         do_frame(tbl[t].id, tbl[t].data, tbl[t].exp_seq, tbl[t].exp_busy, tbl[t].pulse);

      // Reset in the middle of bit 4 of a frame on id0
      @(negedge clk);
      dbuf[0]    = 8'hAA;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (18) @(negedge clk);
      chk("midrst pre_busy", 32'(busy_v[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst cs_n", 32'(cs_v[0]),   32'd1);
      chk("midrst sclk", 32'(sclk_v[0]), 32'(CPOL_P[0]));
      chk("midrst busy", 32'(busy_v[0]), 32'd0);
      chk("midrst mosi", 32'(mosi_v[0]), 32'd0);
`ifdef SPI_MISO_EN
      chk("midrst rx_data", 32'(rxd[0]), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_v[0] || busy_v[0]) ndone++;
      end
      chk("midrst no_done", 32'(ndone), 32'd0);
      do_frame(0, 8'hC3, 8'hC3, 36, 1'b0);

      // Back-to-back frames with start held high on id3 (CLK_DIV=1)
      @(negedge clk);
      dbuf[3]    = 8'h5A;
      start_v[3] = 1'b1;
      run = 0; gap = 0; mism = 0; ndone = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (cs_v[3] !== ~busy_v[3]) mism++;
         if (done_v[3]) ndone++;
         if (busy_v[3]) begin
            if (gap > 0) gaps.push_back(gap);
            gap = 0;
            run++;
         end else begin
            if (run > 0) runs.push_back(run);
            run = 0;
            if (runs.size() > 0) gap++;
         end
      end
      start_v[3] = 1'b0;
      chk("b2b frames", 32'(runs.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("b2b busy_len%0d", i), 32'(i < runs.size() ? runs[i] : 0), 32'd18);
      for (int i = 0; i < 2; i++)
         chk($sformatf("b2b cs_high%0d", i), 32'(i < gaps.size() ? gaps[i] : 0), 32'd1);
      chk("b2b cs_vs_busy", 32'(mism), 32'd0);
      chk("b2b done_count", 32'(ndone), 32'(runs.size()));
      repeat (25) @(negedge clk);

      // Randomised frames against the wire-order model
      for (int n = 0; n < 40; n++) begin
         id = int'($urandom_range(0, NI - 1));
         w  = 8'($urandom);
         do_frame(id, w, wire_order(w, MSB_P[id]), DIV_P[id] * (2 * DW + 2), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
